// File: rtl/dct_mac_pipe.sv
// dct_mac_pipe: pipelined signed multiply-accumulate with variable tap count.
// Stages: operands, full-precision product, accumulate/close, round + saturate/wrap.
module dct_mac_pipe #(
   parameter int DWIDTH = 12,
   parameter int CWIDTH = 16,
   parameter int TAPS   = 8,
   parameter int SHIFT  = 10,
   parameter int RWIDTH = 12,
   parameter int SAT    = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ena,
   input  logic                     in_vld,
   input  logic                     in_last,
   input  logic signed [DWIDTH-1:0] din,
   input  logic signed [CWIDTH-1:0] coef,
   output logic signed [RWIDTH-1:0] result,
   output logic                     out_vld,
   output logic                     tap_err,
   output logic                     busy
);
   localparam int MWIDTH = DWIDTH + CWIDTH;
   localparam int AWIDTH = MWIDTH + $clog2(TAPS);
   localparam int CWID   = $clog2(TAPS) + 1;
   // One guard bit so the rounding increment can never overflow the sum.
   localparam int TWIDTH = AWIDTH + 1;
   localparam int RND_I  = (1 << SHIFT) >> 1;
   localparam logic signed [TWIDTH-1:0] RND  = TWIDTH'(RND_I);
   localparam logic signed [TWIDTH-1:0] RMAX = {{(TWIDTH-RWIDTH+1){1'b0}}, {(RWIDTH-1){1'b1}}};
   localparam logic signed [TWIDTH-1:0] RMIN = ~RMAX;
   localparam logic [CWID-1:0]          LAST_CNT = CWID'(TAPS - 1);

   logic signed [DWIDTH-1:0] din_q, din_d;
   logic signed [CWIDTH-1:0] coef_q, coef_d;
   logic                     vld1_q, vld1_d, last1_q, last1_d;
   logic signed [MWIDTH-1:0] mult_q, mult_d;
   logic                     vld2_q, vld2_d, last2_q, last2_d;
   logic signed [AWIDTH-1:0] acc_q, acc_d, fin_q, fin_d;
   logic signed [AWIDTH-1:0] acc_nxt, prod_ext;
   logic [CWID-1:0]          cnt_q, cnt_d;
   logic                     first_q, first_d, busy_q, busy_d;
   logic                     cls_q, cls_d, err_q, err_d, close;
   logic signed [RWIDTH-1:0] result_q, result_d, res_fmt;
   logic                     out_vld_q, out_vld_d, tap_err_q, tap_err_d;
   logic signed [TWIDTH-1:0] rsum, rshift;

   always_comb begin
      prod_ext = {{(AWIDTH-MWIDTH){mult_q[MWIDTH-1]}}, mult_q};
      acc_nxt  = first_q ? prod_ext : acc_q + prod_ext;
      close    = vld2_q & (last2_q | (cnt_q == LAST_CNT));

      rsum    = {fin_q[AWIDTH-1], fin_q} + RND;
      rshift  = rsum >>> SHIFT;
      res_fmt = rshift[RWIDTH-1:0];
      if (SAT != 0) begin
         if (rshift > RMAX)      res_fmt = RMAX[RWIDTH-1:0];
         else if (rshift < RMIN) res_fmt = RMIN[RWIDTH-1:0];
      end

      din_d     = din_q;
      coef_d    = coef_q;
      vld1_d    = vld1_q;
      last1_d   = last1_q;
      mult_d    = mult_q;
      vld2_d    = vld2_q;
      last2_d   = last2_q;
      acc_d     = acc_q;
      fin_d     = fin_q;
      cnt_d     = cnt_q;
      first_d   = first_q;
      busy_d    = busy_q;
      cls_d     = cls_q;
      err_d     = err_q;
      result_d  = result_q;
      // Pulses drop on any following cycle, enabled or not.
      out_vld_d = 1'b0;
      tap_err_d = 1'b0;

      if (ena) begin
         din_d     = din;
         coef_d    = coef;
         vld1_d    = in_vld;
         last1_d   = in_vld & in_last;
         mult_d    = MWIDTH'(din_q) * MWIDTH'(coef_q);
         vld2_d    = vld1_q;
         last2_d   = last1_q;
         cls_d     = close;
         err_d     = close & ~last2_q;
         out_vld_d = cls_q;
         tap_err_d = err_q;
         if (cls_q) result_d = res_fmt;
         if (vld2_q) begin
            acc_d   = acc_nxt;
            busy_d  = ~close;
            first_d = close;
            cnt_d   = close ? '0 : cnt_q + CWID'(1);
         end
         if (close) fin_d = acc_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         din_q     <= '0;
         coef_q    <= '0;
         vld1_q    <= 1'b0;
         last1_q   <= 1'b0;
         mult_q    <= '0;
         vld2_q    <= 1'b0;
         last2_q   <= 1'b0;
         acc_q     <= '0;
         fin_q     <= '0;
         cnt_q     <= '0;
         first_q   <= 1'b1;
         busy_q    <= 1'b0;
         cls_q     <= 1'b0;
         err_q     <= 1'b0;
         result_q  <= '0;
         out_vld_q <= 1'b0;
         tap_err_q <= 1'b0;
      end else begin
         din_q     <= din_d;
         coef_q    <= coef_d;
         vld1_q    <= vld1_d;
         last1_q   <= last1_d;
         mult_q    <= mult_d;
         vld2_q    <= vld2_d;
         last2_q   <= last2_d;
         acc_q     <= acc_d;
         fin_q     <= fin_d;
         cnt_q     <= cnt_d;
         first_q   <= first_d;
         busy_q    <= busy_d;
         cls_q     <= cls_d;
         err_q     <= err_d;
         result_q  <= result_d;
         out_vld_q <= out_vld_d;
         tap_err_q <= tap_err_d;
      end
   end

   assign result  = result_q;
   assign out_vld = out_vld_q;
   assign tap_err = tap_err_q;
   assign busy    = busy_q;
endmodule
